// File: rtl/dcache_axi_bridge_pkg.sv
// Shared types and constants for the dcache-to-AXI3 bridge.
// AXI sideband constants are tied off by the wrapper that instantiates the bridge.
package dcache_axi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } state_e;

  localparam logic [3:0] AXI_ID    = 4'd1;
  localparam logic [3:0] AXI_LEN   = 4'd0;
  localparam logic [1:0] AXI_BURST = 2'b01;  // INCR
  localparam logic [1:0] AXI_LOCK  = 2'b00;
  localparam logic [3:0] AXI_CACHE = 4'b0000;
  localparam logic [2:0] AXI_PROT  = 3'b000;

endpackage

// File: rtl/dcache_axi_bridge_if.sv
// Sram-like dcache port plus the single-beat AXI3 channels the bridge drives.
// master = bridge side, slave = write buffer / bus side.
interface dcache_axi_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_rdata, data_addr_ok, data_data_ok,
    output araddr, arsize, arvalid, input arready,
    input  rdata, rvalid, output rready,
    output awaddr, awsize, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bvalid, output bready
  );

  modport slave (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_rdata, data_addr_ok, data_data_ok,
    input  araddr, arsize, arvalid, output arready,
    output rdata, rvalid, input rready,
    input  awaddr, awsize, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bvalid, input bready
  );
endinterface

// File: rtl/dcache_axi_bridge.sv
// Converts the write buffer's sram-like port into single-beat AXI3 transactions,
// one outstanding at a time; data_ok lands in IDLE so back-to-back accepts are possible.
module dcache_axi_bridge
  import dcache_axi_bridge_pkg::*;
(
  input logic               clk,
  input logic               rst,
  dcache_axi_bridge_if.master bus
);

  state_e      state;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q, data_ok_q;
  logic        addr_ok, aw_done, w_done;

  assign addr_ok = (state == IDLE) && bus.data_req;
  // A channel counts as done once its valid has dropped or is handshaking now.
  assign aw_done = !awvalid_q || bus.awready;
  assign w_done  = !wvalid_q  || bus.wready;

  assign bus.data_addr_ok = addr_ok;
  assign bus.data_data_ok = data_ok_q;
  assign bus.data_rdata   = rdata_q;
  assign bus.araddr       = addr_q;
  assign bus.arsize       = size_q;
  assign bus.arvalid      = arvalid_q;
  assign bus.rready       = rready_q;
  assign bus.awaddr       = addr_q;
  assign bus.awsize       = size_q;
  assign bus.awvalid      = awvalid_q;
  assign bus.wdata        = wdata_q;
  assign bus.wstrb        = wstrb_q;
  assign bus.wvalid       = wvalid_q;
  assign bus.bready       = bready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      data_ok_q <= 1'b0;
    end else begin
      data_ok_q <= 1'b0;
      case (state)
        IDLE: begin
          if (addr_ok) begin
            addr_q  <= bus.data_addr;
            size_q  <= {1'b0, bus.data_size};
            wdata_q <= bus.data_wdata;
            wstrb_q <= bus.data_wstrb;
            if (bus.data_wr) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= WR_ADDR;
            end else begin
              arvalid_q <= 1'b1;
              state     <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (bus.rvalid) begin
            rready_q  <= 1'b0;
            rdata_q   <= bus.rdata;
            data_ok_q <= 1'b1;
            state     <= IDLE;
          end
        end
        WR_ADDR: begin
          if (bus.awready) awvalid_q <= 1'b0;
          if (bus.wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bus.bvalid) begin
            bready_q  <= 1'b0;
            data_ok_q <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
